// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit unsigned adder around a one-bit full-adder slice
// Optional signed overflow flag and ovf port: define SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    // Full-adder slice fed by the operand LSBs and the carry flop.
    logic x, y, s, co;
    assign x  = a_sh[0];
    assign y  = b_sh[0];
    assign s  = x ^ y ^ carry;
    assign co = (x & y) | ((x ^ y) & carry);

    assign c_out = carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            sum   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        sum   <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    sum   <= {s, sum[WIDTH-1:1]};
                    carry <= co;
                    cnt   <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the MSB cycle, carry is the carry into the MSB and co the carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == IDLE && start) begin
            ovf <= 1'b0;
        end else if (state == RUN && cnt == LAST) begin
            ovf <= carry ^ co;
        end
    end
`endif

endmodule
